// File: rtl/pwm_duty_decoder_if.sv
// Signal bundle for pwm_duty_decoder: PWM input plus the measurement results.
interface pwm_duty_decoder_if #(
  parameter int CNT_WIDTH = 12
);
  logic                 pwm_in;
  logic [CNT_WIDTH-1:0] duty;
  logic [CNT_WIDTH-1:0] period;
  logic                 valid;
  logic                 stuck;
  logic                 stuck_level;

  modport master (
    output pwm_in,
    input  duty, period, valid, stuck, stuck_level
  );

  modport slave (
    input  pwm_in,
    output duty, period, valid, stuck, stuck_level
  );
endinterface

// File: rtl/pwm_duty_decoder.sv
// Recovers high time and period of one PWM input; flags stuck 0%/100% inputs.
// Optional macro PWM_DECODE_GLITCH_FILTER_EN adds a 3-cycle deglitch stage.
module pwm_duty_decoder #(
  parameter int PWM_INTERVAL = 1800,
  parameter int CNT_WIDTH    = 12,
  parameter int TIMEOUT      = 2 * PWM_INTERVAL
) (
  input logic              clk,
  input logic              rst,
  pwm_duty_decoder_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C  = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] INTERVAL_C = CNT_WIDTH'(PWM_INTERVAL);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic [1:0] {SYNC, HIGH, LOW} state_t;

  state_t               state;
  state_t               state_next;
  logic                 s1, s2, s3;
  logic                 lvl;
  logic                 rise, fall;
  logic                 timeout;
  logic                 take_meas;
  logic                 take_timeout;
  logic [CNT_WIDTH-1:0] period_cnt;
  logic [CNT_WIDTH-1:0] high_cnt;
  logic [CNT_WIDTH-1:0] duty_q;
  logic [CNT_WIDTH-1:0] period_q;
  logic                 valid_q;
  logic                 stuck_q;
  logic                 stuck_level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.pwm_in;
      s2 <= s1;
      s3 <= lvl;
    end
  end

`ifdef PWM_DECODE_GLITCH_FILTER_EN
  logic       filt;
  logic [1:0] run;

  // filt follows s2 only once s2 has disagreed with it for 3 consecutive samples
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b0;
      run  <= '0;
    end else if (s2 != filt) begin
      if (run == 2'd2) begin
        filt <= s2;
        run  <= '0;
      end else begin
        run <= run + 2'd1;
      end
    end else begin
      run <= '0;
    end
  end

  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  assign rise = lvl & ~s3;
  assign fall = ~lvl & s3;

  // Holding period_cnt at TIMEOUT and gating on stuck gives exactly one timeout strobe
  assign timeout = (period_cnt == TIMEOUT_C) && !rise && !stuck_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= CNT_ONE;
      high_cnt   <= CNT_ONE;
    end else begin
      if (period_cnt != TIMEOUT_C && period_cnt != CNT_MAX)
        period_cnt <= period_cnt + CNT_ONE;
      if (lvl && high_cnt != CNT_MAX)
        high_cnt <= high_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SYNC;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    take_meas    = 1'b0;
    take_timeout = 1'b0;
    if (rise) begin
      state_next = HIGH;
      take_meas  = (state != SYNC);
    end else if (timeout) begin
      state_next   = SYNC;
      take_timeout = 1'b1;
    end else if (state == HIGH && fall) begin
      state_next = LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q        <= '0;
      period_q      <= '0;
      valid_q       <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      valid_q <= take_meas | take_timeout;
      if (take_meas) begin
        duty_q   <= high_cnt;
        period_q <= period_cnt;
      end
      if (take_timeout) begin
        duty_q        <= s2 ? INTERVAL_C : '0;
        period_q      <= INTERVAL_C;
        stuck_q       <= 1'b1;
        stuck_level_q <= s2;
      end
      if (rise) stuck_q <= 1'b0;
    end
  end

  assign bus.duty        = duty_q;
  assign bus.period      = period_q;
  assign bus.valid       = valid_q;
  assign bus.stuck       = stuck_q;
  assign bus.stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: period table, glitch, mid-period reset, stuck low/high.
module tb_pwm_duty_decoder;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  pwm_duty_decoder_if #(.CNT_WIDTH(12)) bus ();

  pwm_duty_decoder #(
    .PWM_INTERVAL(1800),
    .CNT_WIDTH   (12),
    .TIMEOUT     (3600)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int h;
    int l;
    int duty;
    int period;
  } vec_t;

  typedef struct {
    int duty;
    int period;
    int cyc;
  } strobe_t;

  strobe_t sq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bus.valid === 1'b1)
      sq.push_back('{int'(bus.duty), int'(bus.period), cyc});

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic level, input int n);
    bus.pwm_in = level;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input string name, input int budget);
    int n;
    n = 0;
    while (sq.size() == 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, (sq.size() > 0) ? 1 : 0, 1);
  endtask

  task automatic check_strobe(input string name, input int k, input int d, input int p);
    if (k < sq.size()) begin
      check($sformatf("%s[%0d].duty", name, k), sq[k].duty, d);
      check($sformatf("%s[%0d].period", name, k), sq[k].period, p);
    end else begin
      check($sformatf("%s[%0d].present", name, k), 0, 1);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, ".duty"}, int'(bus.duty), 0);
    check({name, ".period"}, int'(bus.period), 0);
    check({name, ".valid"}, int'(bus.valid), 0);
    check({name, ".stuck"}, int'(bus.stuck), 0);
    check({name, ".stuck_level"}, int'(bus.stuck_level), 0);
  endtask

  vec_t vt[9];
`ifdef PWM_DECODE_GLITCH_FILTER_EN
  localparam int NG = 1;
  int g_duty[NG]   = '{450};
  int g_period[NG] = '{1800};
`else
  localparam int NG = 2;
  int g_duty[NG]   = '{200, 249};
  int g_period[NG] = '{201, 1599};
`endif

  initial begin
    int last_cyc;
    checks   = 0;
    failures = 0;

    vt[0] = '{450, 1350, 450, 1800};
    vt[1] = '{450, 1350, 450, 1800};
    vt[2] = '{900,  900, 900, 1800};
    vt[3] = '{900,  900, 900, 1800};
    vt[4] = '{3,      3,   3,    6};
    vt[5] = '{5,      7,   5,   12};
    vt[6] = '{100, 3400, 100, 3500};
    vt[7] = '{1797,   3, 1797, 1800};
    vt[8] = '{450, 1350, 450, 1800};

    rst        = 1'b1;
    bus.pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    hold(1'b0, 20);

    // Table: every period reported at the following rise; none at the first rise
    foreach (vt[i]) begin
      hold(1'b1, vt[i].h);
      hold(1'b0, vt[i].l);
    end
    hold(1'b1, 10);
    check("table.count", sq.size(), 9);
    foreach (vt[i]) begin
      check_strobe("table", i, vt[i].duty, vt[i].period);
      if (i > 0 && i < sq.size())
        check($sformatf("table[%0d].spacing", i), sq[i].cyc - sq[i-1].cyc, vt[i].period);
    end
    sq.delete();

    // One-cycle low glitch at high cycle 200 of a 450/1800 period
    hold(1'b1, 190);
    hold(1'b0, 1);
    hold(1'b1, 249);
    hold(1'b0, 1350);
    hold(1'b1, 10);
    check("glitch.count", sq.size(), NG);
    for (int k = 0; k < NG; k++) check_strobe("glitch", k, g_duty[k], g_period[k]);
    sq.delete();

    // One-cycle reset at cycle 900 of a 450/1800 period
    hold(1'b1, 440);
    hold(1'b0, 450);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs_zero("midreset");
    hold(1'b0, 899);
    hold(1'b1, 450);
    hold(1'b0, 1350);
    hold(1'b1, 450);
    hold(1'b0, 1350);
    hold(1'b1, 10);
    check("midreset.count", sq.size(), 2);
    check_strobe("midreset", 0, 450, 1800);
    check_strobe("midreset", 1, 450, 1800);
    last_cyc = (sq.size() > 0) ? sq[sq.size()-1].cyc : 0;
    sq.delete();

    // Stuck low after one period
    hold(1'b1, 440);
    bus.pwm_in = 1'b0;
    wait_strobe("stuck0.arrived", 5000);
    check_strobe("stuck0", 0, 0, 1800);
    if (sq.size() > 0) check("stuck0.delay", sq[0].cyc - last_cyc, 3600);
    check("stuck0.stuck", int'(bus.stuck), 1);
    check("stuck0.level", int'(bus.stuck_level), 0);
    hold(1'b0, 300);
    check("stuck0.single_valid", sq.size(), 1);
    sq.delete();

    // Rise clears stuck without a strobe; then stuck high
    hold(1'b1, 10);
    check("unstick.stuck", int'(bus.stuck), 0);
    check("unstick.no_valid", sq.size(), 0);
    wait_strobe("stuck1.arrived", 5000);
    check_strobe("stuck1", 0, 1800, 1800);
    check("stuck1.stuck", int'(bus.stuck), 1);
    check("stuck1.level", int'(bus.stuck_level), 1);
    hold(1'b1, 300);
    check("stuck1.single_valid", sq.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_duty_decoder.md
# pwm_duty_decoder

Measures a single PWM waveform and recovers its high time and period in clock cycles, reporting each completed period with a one-cycle strobe. It is the receive-side counterpart of the LED PWM generators: it can loop back `RGB_R`/`RGB_G`/`RGB_B` (one instance per channel) for self-checking benches and on-board duty readback. It also detects waveforms stuck at 0 % or 100 % duty, which produce no edges.

## Interface
- `PWM_INTERVAL`, 1800: nominal PWM period in clocks. Used for the stuck-output value.
- `CNT_WIDTH`, 12: width of the counters and measurement outputs.
- `TIMEOUT`, 2*PWM_INTERVAL: cycles without a rising edge before the input is declared stuck. Must be less than 2^CNT_WIDTH.
- `clk`  input  1  system clock, single domain.
- `rst`  input  1  synchronous, active-high reset.
- `pwm_in`  input  1  PWM waveform. Asynchronous to `clk`.
- `duty`  output  CNT_WIDTH  high cycles in the last completed period.
- `period`  output  CNT_WIDTH  cycles from rise to rise in the last completed period.
- `valid`  output  1  one-cycle strobe when `duty`/`period` update.
- `stuck`  output  1  high while no rising edge has been seen for TIMEOUT cycles.
- `stuck_level`  output  1  synchronized level of `pwm_in` at the moment `stuck` was raised.

## Operation
**Input front end**
- Two-flop synchronizer `s1`→`s2`, followed by a history flop `s3`. All three reset to 0.
- `rise` = `s2 & ~s3`; `fall` = `~s2 & s3`.

**Counters**
- `period_cnt` and `high_cnt` both saturate at 2^CNT_WIDTH−1 and never wrap.
- On `rise`: both counters load 1.
- Every other cycle: `period_cnt` increments, and `high_cnt` increments when `s2` is 1.
- Result for a clean input: P-cycle period with H high cycles → `period`=P, `duty`=H.

**FSM states**
- SYNC (reset state).
  - On `rise`, go to HIGH.
  - No `valid` is issued, because no full period has been measured yet.
- HIGH.
  - On `fall`, go to LOW.
  - On `rise` (possible only with a glitch-free one-cycle low), behave as in LOW.
- LOW.
  - On `rise`, latch `duty`←`high_cnt` and `period`←`period_cnt`, pulse `valid`, then go to HIGH.

**Timeout (checked in any state)**
- Trigger: `period_cnt`==TIMEOUT and no `rise` in that cycle.
- Actions:
  - Go to SYNC and set `stuck`=1 and `stuck_level`=`s2`.
  - Latch `duty`←(`s2` ? PWM_INTERVAL : 0) and `period`←PWM_INTERVAL.
  - Pulse `valid` once.
- `period_cnt` keeps counting in SYNC so the timeout fires after reset too. It holds at TIMEOUT while stuck, so no further `valid` strobes occur.
- `stuck` clears on the next `rise`, which also enters HIGH without issuing `valid`.

**Simultaneous events:** `rise` has priority over timeout in the same cycle.

**Reset** (asserted at any time, including mid-period):
- All outputs are 0: `duty`, `period`, `valid`, `stuck`, `stuck_level`.
- Counters are 0, state is SYNC, and the synchronizer flops are 0.
- Any partial measurement is discarded.

## Timing
- Let N be the first clock edge that samples `pwm_in` high.
- `s1`=1 after N and `s2`=1 after N+1, so `rise` is true during the cycle following N+1.
- `valid`, `duty` and `period` are registered and change at edge N+2, i.e. 2-cycle latency from sampling.
- `valid` is high for exactly one cycle. `duty`/`period` hold until the next strobe.
- For a periodic input, strobes are spaced exactly P cycles apart.
- The timeout strobe occurs at the edge after `period_cnt` reaches TIMEOUT, i.e. TIMEOUT cycles after the last `rise`.
- There is no backpressure; the consumer must sample on `valid`.

## Configuration
- Macro: `PWM_DECODE_GLITCH_FILTER_EN`.
- **Defined:**
  - A filter stage is inserted between `s2` and `s3`. Its output changes only after `s2` has held the new level for 3 consecutive cycles.
  - Pulses or gaps of fewer than 3 cycles are ignored.
  - Edge latency grows by exactly 3 cycles. Both edges shift equally, so `duty`/`period` are unchanged for clean input.
  - The filter flops reset to 0.
- **Undefined:** `s2` feeds `s3` directly, and every synchronized transition counts as an edge.

## Test plan
1. PWM_INTERVAL=1800 with a 450-high/1350-low waveform → no `valid` at the first rise. After that, `valid` every 1800 cycles with `duty`=450 and `period`=1800.
2. Duty stepped from 450 to 900 at a period boundary → the next strobe reports 900/1800 with no intermediate value.
3. Drive `pwm_in`=0 continuously after one period → 3600 cycles after the last rise: `stuck`=1, `stuck_level`=0, `duty`=0, `period`=1800 and a single `valid`. `stuck` clears on the next rise.
4. Drive `pwm_in`=1 continuously → after 3600 cycles: `stuck`=1, `stuck_level`=1, `duty`=1800, `period`=1800.
5. Assert `rst` for 1 cycle at cycle 900 of a 450/1800 waveform → all outputs read 0. The first `valid` arrives at the second rise after reset, reporting 450/1800.
6. Insert a 1-cycle low glitch at high cycle 200.
   - Macro defined: the strobe still reports 450/1800.
   - Macro undefined: an extra strobe reports `duty`=200, `period`=201.
